// File: rtl/seq_detect_prog_if.sv
// Interface for the programmable sequence detector: the serial data input, the run-time
// configuration, and the match/count outputs. Clock and reset stay outside the interface.
interface seq_detect_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
);
   localparam int LW = $clog2(MAX_LEN + 1);

   logic               in_valid;
   logic               in_bit;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LW-1:0]      cfg_len;
   logic               cfg_overlap;
   logic               clr_count;
   logic               det;
   logic [CNT_W-1:0]   det_count;
   logic               count_sat;

   modport master (
      output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
      input  det, det_count, count_sat
   );

   modport slave (
      input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
      output det, det_count, count_sat
   );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector with a run-time pattern, length and overlap mode,
// a registered one-cycle match pulse and a saturating match counter.
module seq_detect_prog #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b00110011),
   parameter int                 DEF_LEN     = 6,
   parameter bit                 DEF_OVERLAP = 1'b1
) (
   input logic               clk,
   input logic               reset,
   seq_detect_prog_if.slave  bus
);
   localparam int LW = $clog2(MAX_LEN + 1);

   logic [MAX_LEN-1:0] pat_q;
   logic [LW-1:0]      len_q;
   logic               ovl_q;
   logic [MAX_LEN-1:0] hist_q;
   logic [LW-1:0]      fill_q;
   logic               det_q;
   logic [CNT_W-1:0]   count_q;
   logic               sat_q;

   logic [MAX_LEN-1:0] hist_next;
   logic [MAX_LEN-1:0] len_mask;
   logic               len_ok;
   logic               fill_full;
   logic               pattern_hit;
   logic               match;
   logic [CNT_W-1:0]   count_inc;
   logic               count_max;

   // Shadow configuration: only reset or an explicit load may change it
   always_ff @(posedge clk) begin
      if (!reset) begin
         pat_q <= DEF_PATTERN;
         len_q <= LW'(DEF_LEN);
         ovl_q <= DEF_OVERLAP;
      end else if (bus.cfg_load) begin
         pat_q <= bus.cfg_pattern;
         len_q <= bus.cfg_len;
         ovl_q <= bus.cfg_overlap;
      end
   end

   // Match is judged on the history as it will look after this bit is shifted in
   always_comb begin
      hist_next = {hist_q[MAX_LEN-2:0], bus.in_bit};
      len_mask  = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
      len_ok      = (len_q != '0) && (int'(len_q) <= MAX_LEN);
      fill_full   = (int'(fill_q) + 1) >= int'(len_q);
      pattern_hit = ((hist_next ^ pat_q) & len_mask) == '0;
      match       = bus.in_valid && !bus.cfg_load && len_ok && fill_full && pattern_hit;
   end

   // History and fill level; non-overlap mode restarts the fill after each match
   always_ff @(posedge clk) begin
      if (!reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (bus.cfg_load) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (bus.in_valid) begin
         hist_q <= hist_next;
         if (match && !ovl_q) begin
            fill_q <= '0;
         end else if (fill_q < len_q) begin
            fill_q <= fill_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         det_q <= 1'b0;
      end else begin
         det_q <= match;
      end
   end

   always_comb begin
      count_inc = count_q + 1'b1;
      count_max = &count_q;
   end

   // Counter moves on the same edge as the pulse, so a coincident clear always wins
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
         sat_q   <= 1'b0;
      end else if (bus.clr_count) begin
         count_q <= '0;
         sat_q   <= 1'b0;
      end else if (match) begin
         if (!count_max) begin
            count_q <= count_inc;
         end
         if (count_max || (&count_inc)) begin
            sat_q <= 1'b1;
         end
      end
   end

   assign bus.det       = det_q;
   assign bus.det_count = count_q;
   assign bus.count_sat = sat_q;
endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed, table-driven bench for seq_detect_prog: a default-width instance for the main
// scenarios and a 2-bit-counter instance for saturation behaviour.
module tb_seq_detect_prog;
   typedef struct {
      string      tag;
      logic       load;
      logic       clr;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ovl;
      logic       valid;
      logic       b;
      int         exp_det;
      int         exp_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   check_count = 0;
   int   pass_count  = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(8)) bus ();
   seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

   seq_detect_prog dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   seq_detect_prog #(.CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   function automatic vec_t streamVec(string tag, logic valid, logic b, int ed, int ec);
      vec_t v;
      v.tag = tag; v.load = 1'b0; v.clr = 1'b0;
      v.pat = 8'hFF; v.len = 4'd1; v.ovl = 1'b1;
      v.valid = valid; v.b = b; v.exp_det = ed; v.exp_cnt = ec;
      return v;
   endfunction

   function automatic vec_t cfgVec(string tag, logic [7:0] pat, logic [3:0] len, logic ovl);
      vec_t v;
      v.tag = tag; v.load = 1'b1; v.clr = 1'b1;
      v.pat = pat; v.len = len; v.ovl = ovl;
      v.valid = 1'b0; v.b = 1'b0; v.exp_det = 0; v.exp_cnt = 0;
      return v;
   endfunction

   // Drive one cycle of inputs on the main instance and sample just after the edge
   task automatic applyStimulus(input logic load, input logic clr, input logic [7:0] pat,
                                input logic [3:0] len, input logic ovl, input logic valid,
                                input logic b);
      bus.cfg_load    = load;
      bus.clr_count   = clr;
      bus.cfg_pattern = pat;
      bus.cfg_len     = len;
      bus.cfg_overlap = ovl;
      bus.in_valid    = valid;
      bus.in_bit      = b;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      check_count++;
      if (act == exp) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick2();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] pre;
      logic [9:0] post;
      pre  = 4'b1100;
      post = 10'b0011110011;

      reset = 1'b0;
      bus.cfg_load = 1'b0; bus.clr_count = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
      bus.cfg_overlap = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
      bus2.cfg_load = 1'b0; bus2.clr_count = 1'b0; bus2.cfg_pattern = '0; bus2.cfg_len = '0;
      bus2.cfg_overlap = 1'b0; bus2.in_valid = 1'b0; bus2.in_bit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset det", int'(bus.det), 0);
      checkOutput("reset cnt", int'(bus.det_count), 0);
      checkOutput("reset sat", int'(bus.count_sat), 0);
      reset = 1'b1;

      // Defaults (110011, overlapping) on 1100110011
      vecs.push_back(streamVec("T1 b1",  1'b1, 1'b1, 0, 0));
      vecs.push_back(streamVec("T1 b2",  1'b1, 1'b1, 0, 0));
      vecs.push_back(streamVec("T1 b3",  1'b1, 1'b0, 0, 0));
      vecs.push_back(streamVec("T1 b4",  1'b1, 1'b0, 0, 0));
      vecs.push_back(streamVec("T1 b5",  1'b1, 1'b1, 0, 0));
      vecs.push_back(streamVec("T1 b6",  1'b1, 1'b1, 1, 1));
      vecs.push_back(streamVec("T1 b7",  1'b1, 1'b0, 0, 1));
      vecs.push_back(streamVec("T1 b8",  1'b1, 1'b0, 0, 1));
      vecs.push_back(streamVec("T1 b9",  1'b1, 1'b1, 0, 1));
      vecs.push_back(streamVec("T1 b10", 1'b1, 1'b1, 1, 2));
      // Same stream, non-overlapping
      vecs.push_back(cfgVec("T2 cfg", 8'b00110011, 4'd6, 1'b0));
      vecs.push_back(streamVec("T2 b1",  1'b1, 1'b1, 0, 0));
      vecs.push_back(streamVec("T2 b2",  1'b1, 1'b1, 0, 0));
      vecs.push_back(streamVec("T2 b3",  1'b1, 1'b0, 0, 0));
      vecs.push_back(streamVec("T2 b4",  1'b1, 1'b0, 0, 0));
      vecs.push_back(streamVec("T2 b5",  1'b1, 1'b1, 0, 0));
      vecs.push_back(streamVec("T2 b6",  1'b1, 1'b1, 1, 1));
      vecs.push_back(streamVec("T2 b7",  1'b1, 1'b0, 0, 1));
      vecs.push_back(streamVec("T2 b8",  1'b1, 1'b0, 0, 1));
      vecs.push_back(streamVec("T2 b9",  1'b1, 1'b1, 0, 1));
      vecs.push_back(streamVec("T2 b10", 1'b1, 1'b1, 0, 1));
      // 101 with idle gaps
      vecs.push_back(cfgVec("T3 cfg", 8'b00000101, 4'd3, 1'b1));
      vecs.push_back(streamVec("T3 v1",  1'b1, 1'b1, 0, 0));
      vecs.push_back(streamVec("T3 g1",  1'b0, 1'b0, 0, 0));
      vecs.push_back(streamVec("T3 v2",  1'b1, 1'b0, 0, 0));
      vecs.push_back(streamVec("T3 g2",  1'b0, 1'b1, 0, 0));
      vecs.push_back(streamVec("T3 g3",  1'b0, 1'b1, 0, 0));
      vecs.push_back(streamVec("T3 v3",  1'b1, 1'b1, 1, 1));
      vecs.push_back(streamVec("T3 v4",  1'b1, 1'b0, 0, 1));
      vecs.push_back(streamVec("T3 v5",  1'b1, 1'b1, 1, 2));
      vecs.push_back(streamVec("T3 g4",  1'b0, 1'b1, 0, 2));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].load, vecs[i].clr, vecs[i].pat, vecs[i].len, vecs[i].ovl,
                       vecs[i].valid, vecs[i].b);
         checkOutput({vecs[i].tag, " det"}, int'(bus.det), vecs[i].exp_det);
         checkOutput({vecs[i].tag, " cnt"}, int'(bus.det_count), vecs[i].exp_cnt);
      end

      // Reset overrides a coincident load and data bit, and drops a partial match
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 8'hFF, 4'd1, 1'b1, 1'b1, 1'b1);
      reset = 1'b1;
      checkOutput("T4 reset det", int'(bus.det), 0);
      checkOutput("T4 reset cnt", int'(bus.det_count), 0);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(1'b0, 1'b0, 8'hFF, 4'd1, 1'b1, 1'b1, pre[i]);
      end
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'hFF, 4'd1, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      for (int i = 9; i >= 0; i--) begin
         applyStimulus(1'b0, 1'b0, 8'hFF, 4'd1, 1'b1, 1'b1, post[i]);
         checkOutput($sformatf("T4 post b%0d det", 10 - i), int'(bus.det), (i == 0) ? 1 : 0);
      end
      checkOutput("T4 cnt", int'(bus.det_count), 1);
      checkOutput("T4 sat", int'(bus.count_sat), 0);

      // Illegal lengths disable detection
      applyStimulus(1'b1, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 8'hFF, 4'd1, 1'b1, 1'b1, (i == 3) ? 1'b1 : 1'b0);
         checkOutput($sformatf("T6 len0 b%0d det", i), int'(bus.det), 0);
      end
      applyStimulus(1'b1, 1'b1, 8'hFF, 4'd9, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0, 8'hFF, 4'd1, 1'b1, 1'b1, 1'b1);
         checkOutput($sformatf("T6 len9 b%0d det", i), int'(bus.det), 0);
      end
      // A bit arriving with cfg_load is discarded
      applyStimulus(1'b1, 1'b1, 8'h03, 4'd2, 1'b1, 1'b1, 1'b1);
      checkOutput("T6 load det", int'(bus.det), 0);
      applyStimulus(1'b0, 1'b0, 8'hFF, 4'd1, 1'b1, 1'b1, 1'b1);
      checkOutput("T6 first1 det", int'(bus.det), 0);
      applyStimulus(1'b0, 1'b0, 8'hFF, 4'd1, 1'b1, 1'b1, 1'b1);
      checkOutput("T6 second1 det", int'(bus.det), 1);
      checkOutput("T6 cnt", int'(bus.det_count), 1);
      bus.in_valid = 1'b0;

      // Saturation on the 2-bit counter instance
      bus2.cfg_pattern = 8'h01; bus2.cfg_len = 4'd1; bus2.cfg_overlap = 1'b1;
      bus2.cfg_load = 1'b1; bus2.clr_count = 1'b1;
      tick2();
      bus2.cfg_load = 1'b0; bus2.clr_count = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         bus2.in_valid = 1'b1; bus2.in_bit = 1'b1;
         tick2();
         checkOutput($sformatf("T5 one%0d det", i), int'(bus2.det), 1);
         checkOutput($sformatf("T5 one%0d cnt", i), int'(bus2.det_count), (i < 3) ? i : 3);
      end
      checkOutput("T5 sat", int'(bus2.count_sat), 1);
      bus2.in_valid = 1'b0; bus2.clr_count = 1'b1;
      tick2();
      checkOutput("T5 clr cnt", int'(bus2.det_count), 0);
      checkOutput("T5 clr sat", int'(bus2.count_sat), 0);
      bus2.in_valid = 1'b1; bus2.in_bit = 1'b1;
      tick2();
      checkOutput("T5 clr+match det", int'(bus2.det), 1);
      checkOutput("T5 clr+match cnt", int'(bus2.det_count), 0);
      bus2.in_valid = 1'b0; bus2.clr_count = 1'b0;
      tick2();
      checkOutput("T5 idle det", int'(bus2.det), 0);
      checkOutput("T5 idle cnt", int'(bus2.det_count), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
